// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: debounce FSM encoding
// and the default debounce interval (10 ms at 25 MHz).
package button_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_RELEASING = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side bundle of the conditioner: raw pushbutton inputs and the
// debounced levels / press pulses handed to the sprite controller.
interface button_conditioner_if;
  logic btn_left_raw;
  logic btn_right_raw;
  logic btn_up_raw;
  logic btn_down_raw;
  logic btn_fire_raw;
  logic btn_left;
  logic btn_right;
  logic btn_up;
  logic btn_down;
  logic btn_fire;
  logic press_left;
  logic press_right;
  logic press_up;
  logic press_down;
  logic press_fire;

  modport master (
    output btn_left_raw, btn_right_raw, btn_up_raw, btn_down_raw, btn_fire_raw,
    input  btn_left, btn_right, btn_up, btn_down, btn_fire,
    input  press_left, press_right, press_up, press_down, press_fire
  );

  modport slave (
    input  btn_left_raw, btn_right_raw, btn_up_raw, btn_down_raw, btn_fire_raw,
    output btn_left, btn_right, btn_up, btn_down, btn_fire,
    output press_left, press_right, press_up, press_down, press_fire
  );
endinterface

// File: rtl/button_conditioner_debounce_cell.sv
// One button: 2-flop synchronizer, debounce FSM with saturating-free counter,
// registered press pulse and the level the FSM will hold after the next edge.
module btn_debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk25,
  input  logic rst,
  input  logic i_raw,
  output logic o_press,
  output logic o_level_nxt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= i_raw;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_sync) begin
            r_state <= ST_ARMING;
            r_cnt   <= '0;
          end
        end
        ST_ARMING: begin
          if (!r_sync) begin
            r_state <= ST_IDLE;
          end else if (w_cnt_done) begin
            r_state <= ST_PRESSED;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!r_sync) begin
            r_state <= ST_RELEASING;
            r_cnt   <= '0;
          end
        end
        ST_RELEASING: begin
          // A bounce back to 1 resumes the press without a new pulse.
          if (r_sync) begin
            r_state <= ST_PRESSED;
          end else if (w_cnt_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Level after the coming edge, so the top can register the masked result
  // without adding a cycle of latency.
  always_comb begin
    o_level_nxt = 1'b0;
    case (r_state)
      ST_IDLE:      o_level_nxt = 1'b0;
      ST_ARMING:    o_level_nxt = r_sync & w_cnt_done;
      ST_PRESSED:   o_level_nxt = 1'b1;
      ST_RELEASING: o_level_nxt = r_sync | ~w_cnt_done;
      default:      o_level_nxt = 1'b0;
    endcase
  end

  assign o_press = r_press;

endmodule

// File: rtl/button_conditioner.sv
// Five independent debounce cells plus opposing-direction conflict masking;
// all outputs come straight from flops.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk25,
  input  logic                rst,
  button_conditioner_if.slave bus
);

  // Bit order everywhere: {fire, down, up, right, left}
  logic [4:0] w_raw;
  logic [4:0] w_press;
  logic [4:0] w_lvl_nxt;
  logic [4:0] r_btn;

  assign w_raw = {bus.btn_fire_raw, bus.btn_down_raw, bus.btn_up_raw,
                  bus.btn_right_raw, bus.btn_left_raw};

  for (genvar g = 0; g < 5; g++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk25      (clk25),
      .rst        (rst),
      .i_raw      (w_raw[g]),
      .o_press    (w_press[g]),
      .o_level_nxt(w_lvl_nxt[g])
    );
  end

  // Opposing directions cancel; fire is never masked.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_btn <= '0;
    end else begin
      r_btn[0] <= w_lvl_nxt[0] & ~w_lvl_nxt[1];
      r_btn[1] <= w_lvl_nxt[1] & ~w_lvl_nxt[0];
      r_btn[2] <= w_lvl_nxt[2] & ~w_lvl_nxt[3];
      r_btn[3] <= w_lvl_nxt[3] & ~w_lvl_nxt[2];
      r_btn[4] <= w_lvl_nxt[4];
    end
  end

  assign bus.btn_left    = r_btn[0];
  assign bus.btn_right   = r_btn[1];
  assign bus.btn_up      = r_btn[2];
  assign bus.btn_down    = r_btn[3];
  assign bus.btn_fire    = r_btn[4];
  assign bus.press_left  = w_press[0];
  assign bus.press_right = w_press[1];
  assign bus.press_up    = w_press[2];
  assign bus.press_down  = w_press[3];
  assign bus.press_fire  = w_press[4];

endmodule

// File: tb/tb_button_conditioner.sv
// Segment-table bench for button_conditioner with DEBOUNCE_CYCLES=4:
// each segment holds raw pins for N cycles, then checks levels and pulse counts.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam logic [4:0] BL = 5'b00001;
  localparam logic [4:0] BR = 5'b00010;
  localparam logic [4:0] BU = 5'b00100;
  localparam logic [4:0] BD = 5'b01000;
  localparam logic [4:0] BF = 5'b10000;
  localparam logic [4:0] B0 = 5'b00000;

  typedef struct {
    string      name;
    logic [4:0] raw;
    int         cycles;
    logic [4:0] exp_btn;
    logic [4:0] exp_press;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] btn;
    logic [4:0] press;
  } exp_t;

  logic clk25;
  logic rst;
  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk25(clk25),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [4:0] obs_btn();
    return {bus.btn_fire, bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left};
  endfunction

  function automatic logic [4:0] obs_press();
    return {bus.press_fire, bus.press_down, bus.press_up, bus.press_right, bus.press_left};
  endfunction

  task automatic drive_raw(input logic [4:0] r);
    bus.btn_left_raw  = r[0];
    bus.btn_right_raw = r[1];
    bus.btn_up_raw    = r[2];
    bus.btn_down_raw  = r[3];
    bus.btn_fire_raw  = r[4];
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if (obs_btn() !== B0 || obs_press() !== B0) begin
      n_bad++;
      $display("FAIL %s: btn=%b press=%b, required all 0", name, obs_btn(), obs_press());
    end
  endtask

  // Hold raw for 'cycles' edges; expect the level vector at the end and the
  // number of press pulses per button seen during the segment.
  task automatic run_seg(input string name, input logic [4:0] raw, input int cycles,
                         input logic [4:0] eb, input logic [4:0] ep);
    int         cnt [5];
    logic [4:0] p;
    exp_t       e;
    bit         ok;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    sb_q.push_back('{name, eb, ep});
    drive_raw(raw);
    for (int c = 0; c < cycles; c++) begin
      tick();
      p = obs_press();
      for (int i = 0; i < 5; i++) cnt[i] += int'(p[i]);
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (obs_btn() !== e.btn) begin
      n_bad++;
      $display("FAIL %s.btn: got %b, required %b", e.name, obs_btn(), e.btn);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) if (cnt[i] != int'(e.press[i])) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s.press: pulses f/d/u/r/l = %0d/%0d/%0d/%0d/%0d, required %b",
               e.name, cnt[4], cnt[3], cnt[2], cnt[1], cnt[0], e.press);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_raw(B0);
    tick();
    tick();
    check_zero("reset_state");
    rst = 1'b0;

    // {name, raw, cycles, expected levels at end, expected pulse count per button}
    tbl.push_back('{"idle",          B0,      4, B0,      B0});
    tbl.push_back('{"left_pre",      BL,      6, B0,      B0});
    tbl.push_back('{"left_rise",     BL,      1, BL,      BL});
    tbl.push_back('{"left_hold",     BL,      8, BL,      B0});
    tbl.push_back('{"left_rel_pre",  B0,      6, BL,      B0});
    tbl.push_back('{"left_rel",      B0,      1, B0,      B0});
    tbl.push_back('{"fire_glitch",   BF,      3, B0,      B0});
    tbl.push_back('{"fire_gl_tail",  B0,      8, B0,      B0});
    tbl.push_back('{"lr_press",      BL|BR,   7, B0,      BL|BR});
    tbl.push_back('{"lr_hold",       BL|BR,   3, B0,      B0});
    tbl.push_back('{"r_rel_pre",     BL,      6, B0,      B0});
    tbl.push_back('{"r_rel",         BL,      1, BL,      B0});
    tbl.push_back('{"lr_clear",      B0,     10, B0,      B0});
    tbl.push_back('{"ud_press",      BU|BD,   7, B0,      BU|BD});
    tbl.push_back('{"ud_clear",      B0,     10, B0,      B0});
    tbl.push_back('{"multi_press",   BL|BU|BF, 7, BL|BU|BF, BL|BU|BF});
    tbl.push_back('{"multi_clear",   B0,     10, B0,      B0});
    tbl.push_back('{"up_bounce1",    BU,      2, B0,      B0});
    tbl.push_back('{"up_bounce0",    B0,      2, B0,      B0});
    tbl.push_back('{"up_bounce1b",   BU,      2, B0,      B0});
    tbl.push_back('{"up_bounce0b",   B0,      2, B0,      B0});
    tbl.push_back('{"up_stable_pre", BU,      6, B0,      B0});
    tbl.push_back('{"up_stable",     BU,      1, BU,      BU});
    tbl.push_back('{"up_clear",      B0,     10, B0,      B0});
    tbl.push_back('{"fire_press",    BF,      7, BF,      BF});
    tbl.push_back('{"fire_hold",     BF,      3, BF,      B0});
    tbl.push_back('{"fire_drop",     B0,      2, BF,      B0});
    tbl.push_back('{"fire_back",     BF,     10, BF,      B0});
    tbl.push_back('{"fire_clear",    B0,     10, B0,      B0});

    foreach (tbl[k])
      run_seg(tbl[k].name, tbl[k].raw, tbl[k].cycles, tbl[k].exp_btn, tbl[k].exp_press);

    // Reset while a button is held in PRESSED: outputs drop at once, full re-debounce after.
    run_seg("rp_pre",   BL, 6, B0, B0);
    run_seg("rp_rise",  BL, 1, BL, BL);
    run_seg("rp_hold",  BL, 3, BL, B0);
    #5 rst = 1'b1;
    #1 check_zero("rst_async_pressed");
    tick();
    check_zero("rst_held_pressed");
    tick();
    rst = 1'b0;
    run_seg("rp_after_pre", BL, 6, B0, B0);
    run_seg("rp_after",     BL, 1, BL, BL);
    run_seg("rp_clear",     B0, 10, B0, B0);

    // Reset in the middle of ARMING: progress discarded, single pulse later.
    run_seg("ra_arm", BD, 3, B0, B0);
    rst = 1'b1;
    #1 check_zero("rst_async_arming");
    tick();
    check_zero("rst_held_arming");
    tick();
    rst = 1'b0;
    run_seg("ra_after_pre", BD, 6, B0, B0);
    run_seg("ra_after",     BD, 1, BD, BD);
    run_seg("ra_hold",      BD, 5, BD, B0);
    run_seg("ra_clear",     B0, 10, B0, B0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable clk25 cycles needed to accept a level change (10 ms at 25 MHz); legal range 2..2^20.
REQ-002 clk25  input  1  system pixel clock; the block SHALL use one clock only.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 btn_left_raw, btn_right_raw, btn_up_raw, btn_down_raw, btn_fire_raw  input  1 each  raw pushbutton pins; asynchronous to clk25; bouncing.
REQ-005 btn_left, btn_right, btn_up, btn_down  output  1 each  debounced, conflict-masked direction levels for the sprite movement controller.
REQ-006 btn_fire  output  1  debounced fire level.
REQ-007 press_left, press_right, press_up, press_down, press_fire  output  1 each  single-cycle pulse on each accepted press.

Function
REQ-008 Each raw input SHALL pass through a 2-flop synchronizer; only the second flop (sync) SHALL feed logic.
REQ-009 Each button SHALL have an independent FSM with states IDLE, ARMING, PRESSED, RELEASING and a down-counter-free up-counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-010 IDLE: sync=1 -> ARMING, cnt<=0; else stay.
REQ-011 ARMING: sync=0 -> IDLE; cnt==DEBOUNCE_CYCLES-1 -> PRESSED; else cnt<=cnt+1.
REQ-012 PRESSED: sync=0 -> RELEASING, cnt<=0; else stay.
REQ-013 RELEASING: sync=1 -> PRESSED (no new pulse); cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt<=cnt+1.
REQ-014 Internal level SHALL be 1 in PRESSED and RELEASING, 0 in IDLE and ARMING; all outputs SHALL be registered.
REQ-015 Latency: with raw held high from before clock edge E0, level and press pulse SHALL assert after edge E0+DEBOUNCE_CYCLES+2; release latency identical.
REQ-016 press_* SHALL be high for exactly one cycle, on the ARMING->PRESSED transition only; a bounce in RELEASING SHALL NOT re-pulse.
REQ-017 Conflict mask: when internal left and right levels are both 1, btn_left and btn_right SHALL both be 0; same rule for up/down; press_* pulses are unmasked.
REQ-018 cnt SHALL never wrap; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
REQ-019 Buttons SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses.

Reset
REQ-020 rst=1 SHALL immediately force synchronizer flops to 0, all FSMs to IDLE, cnt to 0, all outputs to 0.
REQ-021 Reset asserted mid-ARMING or mid-PRESSED SHALL discard progress; after release a held button SHALL need the full REQ-015 latency and SHALL pulse once.
REQ-022 Reset release SHALL be synchronized externally; the block SHALL NOT assume any output state other than REQ-020 until the first edge after deassertion.

Structure
REQ-023 Shared package SHALL hold the state encoding (IDLE/ARMING/PRESSED/RELEASING) and DEBOUNCE_CYCLES default constant.
REQ-024 One sub-module, btn_debounce_cell (synchronizer + FSM + counter + pulse), SHALL be instantiated five times; conflict masking SHALL live in the top.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Clean press: left_raw 0->1 held -> btn_left=1 and press_left=1 for one cycle after edge E0+6; released -> btn_left=0 after further 6 edges.
REQ-026 Bounce: up_raw toggles 1,0,1,0 every 2 cycles then stable 1 -> exactly one press_up, btn_up rises 6 edges after final stable rise.
REQ-027 Glitch: fire_raw high 3 cycles then low -> btn_fire and press_fire stay 0.
REQ-028 Conflict: left and right held together -> both press pulses fire, btn_left=btn_right=0; release right -> btn_left=1 six edges later.
REQ-029 Reset mid-ARMING: down_raw high, rst pulsed after 3 cycles, down_raw still high -> outputs 0 during rst, press_down once 6 edges after rst deassert.
REQ-030 Release bounce: btn_fire held, fire_raw drops 2 cycles then returns -> btn_fire stays 1, no second press_fire.
